seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/hex7_decode.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 4-digit seven-segment scanner.
// Glyphs are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  en;
  } frame_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Entry n is the glyph for hex digit n; the most significant slot holds F.
  localparam logic [15:0][6:0] GLYPH_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = GLYPH_TBL[i_nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit scanner: BLANK/DRIVE per digit, with a shadow
// register committed only at the frame boundary so a frame is never torn.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DRIVE_CYC = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_start,
  output logic        pending
);

  localparam int MAXC = (DRIVE_CYC > BLANK_CYC) ? DRIVE_CYC : BLANK_CYC;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] DRV_LAST = CW'(DRIVE_CYC - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);

  state_t        r_state;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  frame_t        r_frame;
  frame_t        r_shadow;
  logic          r_pending;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;
  logic          r_fs;

  logic       w_blk_end;
  logic       w_drv_end;
  logic       w_commit;
  frame_t     w_frame_nxt;
  logic [3:0] w_nib;
  logic [6:0] w_glyph;
  logic [3:0] w_an_drv;

  assign w_blk_end = (r_state == ST_BLANK) && (r_cnt == BLK_LAST);
  assign w_drv_end = (r_state == ST_DRIVE) && (r_cnt == DRV_LAST);
  assign w_commit  = w_blk_end && (r_idx == 2'd0);

  // Outputs for the slot being entered are decoded from the frame as it will
  // be after this edge, so digit 0 of a freshly committed frame is correct.
  assign w_frame_nxt = (w_commit && r_pending) ? r_shadow : r_frame;
  assign w_nib       = w_frame_nxt.val[{r_idx, 2'b00} +: 4];
  assign w_an_drv    = ~(4'b0001 << r_idx);

  hex7_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_BLANK;
      r_idx     <= 2'd0;
      r_cnt     <= '0;
      r_frame   <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_seg     <= SEG_BLANK;
      r_dp      <= 1'b1;
      r_an      <= AN_OFF;
      r_fs      <= 1'b0;
    end else begin
      r_fs <= w_commit;

      // A load on the commit edge lands in the shadow after the old shadow
      // has moved to the frame, so pending stays set for the next frame.
      if (load) begin
        r_shadow  <= {value, dp_in, digit_en};
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
      if (w_commit && r_pending) r_frame <= r_shadow;

      case (r_state)
        ST_BLANK: begin
          if (w_blk_end) begin
            r_state <= ST_DRIVE;
            r_cnt   <= '0;
            // A disabled digit keeps its cathodes dark as well as its anode.
            if (w_frame_nxt.en[r_idx]) begin
              r_an  <= w_an_drv;
              r_seg <= w_glyph;
              r_dp  <= ~w_frame_nxt.dp[r_idx];
            end else begin
              r_an  <= AN_OFF;
              r_seg <= SEG_BLANK;
              r_dp  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (w_drv_end) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= r_idx + 2'd1;
            r_an    <= AN_OFF;
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_BLANK;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign an          = r_an;
  assign frame_start = r_fs;
  assign pending     = r_pending;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed scoreboard bench for seg7_scan_ctrl with DRIVE_CYC=4, BLANK_CYC=2.
module tb_seg7_scan_ctrl;

  localparam int DC = 4;
  localparam int BC = 2;
  localparam int FRAME = 4 * (DC + BC);
  localparam int NONE = -10;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  localparam slot_t BLANK_SLOT = {4'hF, 7'h7F, 1'b1};
  localparam logic [6:0] GL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;
  logic        pending;

  int checks = 0;
  int failures = 0;
  slot_t sb[$];

  seg7_scan_ctrl #(.DRIVE_CYC(DC), .BLANK_CYC(BC)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .load        (load),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    for (int k = 0; k < 4; k++) begin
      slot_t s;
      logic [3:0] onehot;
      onehot = 4'b0001 << k;
      if (e[k]) s = {~onehot, GL[v[4*k +: 4]], ~d[k]};
      else      s = BLANK_SLOT;
      sb.push_back(s);
    end
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    load = 1'b1; value = v; dp_in = d; digit_en = e;
  endtask

  // Entered at the negedge where frame_start is expected; leaves at the
  // negedge of the next frame's first cycle.
  task automatic check_frame(input int l1, input logic [15:0] v1, input int l2,
                             input logic [15:0] v2, input logic [3:0] d,
                             input logic [3:0] e, input logic p0);
    slot_t cur, exp;
    cur = BLANK_SLOT;
    for (int off = 0; off < FRAME; off++) begin
      if (off > 0) begin
        @(negedge clk);
        load = 1'b0;
      end
      if (off % (DC + BC) == 0) begin
        chk($sformatf("sb_avail@%0d", off), 16'(sb.size() != 0), 16'd1);
        if (sb.size() != 0) cur = sb.pop_front();
      end
      exp = (off % (DC + BC) < DC) ? cur : BLANK_SLOT;
      chk($sformatf("an@%0d", off), 16'(an), 16'(exp.an));
      chk($sformatf("seg@%0d", off), 16'(seg), 16'(exp.seg));
      chk($sformatf("dp@%0d", off), 16'(dp), 16'(exp.dp));
      chk($sformatf("frame_start@%0d", off), 16'(frame_start), 16'(off == 0));
      if (off == 0) chk("pending_at_commit", 16'(pending), 16'(p0));
      if (off == l1 + 1 || off == l2 + 1) chk($sformatf("pending_after_load@%0d", off), 16'(pending), 16'd1);
      if (off == l1) drive_load(v1, d, e);
      if (off == l2) drive_load(v2, d, e);
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int n;
    bit found;

    repeat (3) @(negedge clk);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp", 16'(dp), 16'd1);
    chk("rst_frame_start", 16'(frame_start), 16'd0);
    chk("rst_pending", 16'(pending), 16'd0);

    rst = 1'b0;
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      n++;
      if (frame_start) found = 1'b1;
    end
    chk("first_frame_latency", 16'(n), 16'd2);

    // Idle frame, then 1234; AAAA overwritten by 5555 before commit.
    push_frame(16'h0000, 4'h0, 4'h0);
    check_frame(5, 16'h1234, NONE, 16'h0, 4'h0, 4'hF, 1'b0);
    push_frame(16'h1234, 4'h0, 4'hF);
    check_frame(3, 16'hAAAA, 14, 16'h5555, 4'h0, 4'hF, 1'b0);
    push_frame(16'h5555, 4'h0, 4'hF);
    // Second load coincides with commit: 8F08 shown first, 1A0F a frame later.
    check_frame(4, 16'h8F08, FRAME - 1, 16'h1A0F, 4'h0, 4'hF, 1'b0);
    push_frame(16'h8F08, 4'h0, 4'hF);
    check_frame(NONE, 16'h0, NONE, 16'h0, 4'h0, 4'hF, 1'b1);
    push_frame(16'h1A0F, 4'h0, 4'hF);
    check_frame(10, 16'hC3E6, NONE, 16'h0, 4'b0001, 4'b0101, 1'b0);
    push_frame(16'hC3E6, 4'b0001, 4'b0101);
    check_frame(NONE, 16'h0, NONE, 16'h0, 4'h0, 4'h0, 1'b0);

    // Reset in the middle of digit 2 DRIVE with a load pending.
    for (int off = 1; off <= 13; off++) begin
      @(negedge clk);
      load = 1'b0;
      if (off == 8) drive_load(16'h9999, 4'h0, 4'hF);
    end
    chk("mid_drive_an_idx2", 16'(an), 16'b1011);
    chk("mid_drive_seg_idx2", 16'(seg), 16'(GL[3]));
    chk("mid_drive_pending", 16'(pending), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_an", 16'(an), 16'hF);
    chk("async_rst_seg", 16'(seg), 16'h7F);
    chk("async_rst_dp", 16'(dp), 16'd1);
    chk("async_rst_pending", 16'(pending), 16'd0);
    repeat (2) @(negedge clk);

    // Load in the first cycle after release must reach the first frame.
    rst = 1'b0;
    drive_load(16'h2B6D, 4'b1000, 4'hF);
    @(negedge clk);
    load = 1'b0;
    chk("restart_frame_start_early", 16'(frame_start), 16'd0);
    chk("restart_pending", 16'(pending), 16'd1);
    chk("restart_blank_an", 16'(an), 16'hF);
    @(negedge clk);
    push_frame(16'h2B6D, 4'b1000, 4'hF);
    check_frame(NONE, 16'h0, NONE, 16'h0, 4'h0, 4'hF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
